vdot_acc_pipe: RTL and testbench

- Parametrised successor of the 4-lane 8-bit vector dot-product unit.
- Computes a dot product over LANES elements of DW bits per beat.
- Accumulates across multiple beats, ended by in_last, so long vectors stream through a fixed-width lane array.
- 3-stage pipeline (multiply, adder tree, accumulate) with valid/ready handshakes on input and output; per-beat signed/unsigned mode; feeds the core's result write-back path.

---
 rtl/vdot_pkg.sv | 34 +++
 rtl/vdot_lane_mul.sv | 30 +++
 rtl/vdot_acc_pipe.sv | 168 ++++++++++++++++
 tb/tb_vdot_acc_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdot_pkg.sv
// Shared defaults and helper functions for the vdot_acc_pipe dot-product unit.
// The optional saturating accumulator is enabled with the VDOT_SAT_EN macro.
package vdot_pkg;

    localparam int LANES_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int ACCW_DEF  = 32;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v = value - 1;
        while (v > 0) begin
            res = res + 1;
            v = v >>> 1;
        end
        return res;
    endfunction

    // Fill bit used when widening a value: the MSB in signed mode, zero otherwise.
    function automatic logic ext_bit(input logic is_signed, input logic msb);
        return is_signed & msb;
    endfunction

    function automatic logic add_ovf(input logic is_signed, input logic a_msb,
                                     input logic b_msb, input logic sum_msb,
                                     input logic carry);
        if (is_signed)
            return (a_msb == b_msb) && (sum_msb != a_msb);
        return carry;
    endfunction

endpackage

// File: rtl/vdot_lane_mul.sv
// One DW x DW lane multiplier with signed select and a registered 2*DW product.
// The low 2*DW bits of the widened product are exact in both modes.
module vdot_lane_mul #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            is_signed,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] prod
);

    logic [2*DW-1:0] a_x;
    logic [2*DW-1:0] b_x;
    logic [2*DW-1:0] full;

    assign a_x  = {{DW{is_signed & a[DW-1]}}, a};
    assign b_x  = {{DW{is_signed & b[DW-1]}}, b};
    assign full = a_x * b_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (en)
            prod <= full;
    end

endmodule

// File: rtl/vdot_acc_pipe.sv
// Three-stage streaming dot product (multiply, adder tree, accumulate) with valid/ready.
// Define VDOT_SAT_EN for a saturating accumulator and a sticky out_ovf flag.
module vdot_acc_pipe
    import vdot_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic                in_signed,
    input  logic [LANES*DW-1:0] in_a,
    input  logic [LANES*DW-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACCW-1:0]     out_res,
    output logic                out_ovf
);

    localparam int LG   = clog2(LANES);
    localparam int SUMW = 2*DW + LG;

    logic            stall;
    logic            load_res;
    logic            s1_valid;
    logic            s1_last;
    logic            s1_signed;
    logic [2*DW-1:0] prod [LANES];
    logic [SUMW-1:0] tree_sum;
    logic [ACCW-1:0] tree_ext;
    logic            s2_valid;
    logic            s2_last;
    logic [ACCW-1:0] s2_sum;
    logic            first;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_base;
    logic [ACCW-1:0] acc_next;

    // Only a second final result can collide with an unconsumed one; partial beats keep flowing.
    assign stall    = out_valid && !out_ready && s2_valid && s2_last;
    assign in_ready = !stall;
    assign load_res = s2_valid && s2_last && !stall;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vdot_lane_mul #(.DW(DW)) u_mul (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (in_ready),
            .is_signed (in_signed),
            .a         (in_a[i*DW +: DW]),
            .b         (in_b[i*DW +: DW]),
            .prod      (prod[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_signed <= in_signed;
        end
    end

    // The tree is sized for exact sums of LANES products, then widened to ACCW.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++)
            tree_sum = tree_sum + {{LG{ext_bit(s1_signed, prod[i][2*DW-1])}}, prod[i]};
        tree_ext = s1_signed ? ACCW'($signed(tree_sum)) : ACCW'(tree_sum);
    end

`ifdef VDOT_SAT_EN
    logic            s2_signed;
    logic [ACCW:0]   raw_sum;
    logic            beat_ovf;
    logic            ovf_acc;
    logic            ovf_next;
    logic            ovf_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s2_signed <= 1'b0;
        else if (!stall)
            s2_signed <= s1_signed;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= tree_ext;
        end
    end

    assign acc_base = first ? '0 : acc;

`ifdef VDOT_SAT_EN
    // Clamp towards the side the running sum was on; unsigned beats can only overflow upward.
    always_comb begin
        raw_sum  = {1'b0, acc_base} + {1'b0, s2_sum};
        beat_ovf = add_ovf(s2_signed, acc_base[ACCW-1], s2_sum[ACCW-1],
                           raw_sum[ACCW-1], raw_sum[ACCW]);
        acc_next = raw_sum[ACCW-1:0];
        if (beat_ovf) begin
            if (!s2_signed)
                acc_next = '1;
            else if (acc_base[ACCW-1])
                acc_next = {1'b1, {(ACCW-1){1'b0}}};
            else
                acc_next = {1'b0, {(ACCW-1){1'b1}}};
        end
        ovf_next = (!first && ovf_acc) || beat_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc <= 1'b0;
            ovf_res <= 1'b0;
        end else if (s2_valid && !stall) begin
            if (s2_last)
                ovf_res <= ovf_next;
            else
                ovf_acc <= ovf_next;
        end
    end

    assign out_ovf = ovf_res;
`else
    assign acc_next = acc_base + s2_sum;
    assign out_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= '0;
        end else begin
            if (load_res) begin
                out_res   <= acc_next;
                out_valid <= 1'b1;
                first     <= 1'b1;
            end else begin
                if (s2_valid && !stall) begin
                    acc   <= acc_next;
                    first <= 1'b0;
                end
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdot_acc_pipe.sv
// Directed, table-driven bench for vdot_acc_pipe (default 4x8-bit, 32-bit accumulator)
// plus an 18-bit accumulator instance for wrap/saturation (VDOT_SAT_EN) behaviour.
module tb_vdot_acc_pipe;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int ACCW  = 32;
    localparam int W     = LANES * DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            in_signed = 1'b0;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic            out_ready = 1'b1;
    logic            in_ready;
    logic            out_valid;
    logic [ACCW-1:0] out_res;
    logic            out_ovf;

    logic            n_valid = 1'b0;
    logic            n_last = 1'b0;
    logic            n_signed = 1'b0;
    logic [W-1:0]    n_a = '0;
    logic [W-1:0]    n_b = '0;
    logic            n_out_ready = 1'b1;
    logic            n_in_ready;
    logic            n_out_valid;
    logic [17:0]     n_out_res;
    logic            n_out_ovf;

    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic            sgn;
        logic [ACCW-1:0] exp;
    } vec_t;

    vec_t            vecs[8];
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    logic [ACCW-1:0] got_res[$];
    logic            got_ovf[$];
    int              got_cyc[$];
    int              acc_cyc[$];
    int              tt[8];
    int              t;
    int              t0;

    always #5 clk = ~clk;

    vdot_acc_pipe #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_ovf(out_ovf)
    );

    vdot_acc_pipe #(.LANES(LANES), .DW(DW), .ACCW(18)) u_dut18 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_in_ready),
        .in_last(n_last), .in_signed(n_signed), .in_a(n_a), .in_b(n_b),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_res(n_out_res), .out_ovf(n_out_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_res.push_back(out_res);
            got_ovf.push_back(out_ovf);
            got_cyc.push_back(cyc);
        end
        if (rst_n && in_valid && in_ready && in_last)
            acc_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", name);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input logic last);
        int n;
        n = 0;
        in_a = a; in_b = b; in_signed = sgn; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) reportTimeout("accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic popResult(input string name, input logic [31:0] exp_res,
                             input logic exp_ovf, output int tc);
        int n;
        logic [ACCW-1:0] r;
        logic o;
        n = 0;
        tc = -1;
        while (got_res.size() == 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (got_res.size() == 0) begin
            reportTimeout(name);
        end else begin
            r = got_res.pop_front();
            o = got_ovf.pop_front();
            tc = got_cyc.pop_front();
            checkOutput(name, r, exp_res);
            checkOutput({name, "_ovf"}, 32'(o), 32'(exp_ovf));
        end
    endtask

    task automatic applyNarrow(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sgn, input logic last);
        int n;
        n = 0;
        n_a = a; n_b = b; n_signed = sgn; n_last = last; n_valid = 1'b1;
        while (!n_in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!n_in_ready) reportTimeout("narrow_accept");
        @(posedge clk); #1;
        n_valid = 1'b0;
        n_last = 1'b0;
    endtask

    task automatic waitNarrow(input string name, input logic [31:0] exp_res, input logic exp_ovf);
        int n;
        n = 0;
        while (!n_out_valid && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (!n_out_valid) begin
            reportTimeout(name);
        end else begin
            checkOutput(name, 32'(n_out_res), exp_res);
            checkOutput({name, "_ovf"}, 32'(n_out_ovf), 32'(exp_ovf));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{pk(8'd1, 8'd2, 8'd3, 8'd4), pk(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 32'd70};
        vecs[1] = '{pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'h01, 8'h01, 8'h01, 8'h01), 1'b1, 32'hFFFF_FFFC};
        vecs[2] = '{pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 32'd260100};
        vecs[3] = '{pk(8'h80, 8'h80, 8'h80, 8'h80), pk(8'h80, 8'h80, 8'h80, 8'h80), 1'b1, 32'd65536};
        vecs[4] = '{pk(8'h7F, 8'h80, 8'h00, 8'hFF), pk(8'h7F, 8'h7F, 8'h05, 8'hFF), 1'b1, 32'hFFFF_FF82};
        vecs[5] = '{pk(8'hFF, 8'h00, 8'h00, 8'h00), pk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 32'd255};
        vecs[6] = '{pk(8'hFF, 8'h00, 8'h00, 8'h00), pk(8'h01, 8'h00, 8'h00, 8'h00), 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{pk(8'h80, 8'h80, 8'h80, 8'h80), pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 32'd130560};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_res", out_res, 32'd0);
        checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single beat latency");
        applyStimulus(vecs[0].a, vecs[0].b, vecs[0].sgn, 1'b1);
        popResult("lat_res", 32'd70, 1'b0, t);
        t0 = (acc_cyc.size() > 0) ? acc_cyc.pop_front() : -100;
        checkOutput("lat_cycles", 32'(t - t0), 32'd3);

        $display("[TB] back-to-back table");
        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b1);
        for (int i = 0; i < 8; i++)
            popResult($sformatf("vec%0d", i), vecs[i].exp, 1'b0, tt[i]);
        for (int i = 1; i < 8; i++)
            checkOutput($sformatf("no_bubble%0d", i), 32'(tt[i] - tt[i-1]), 32'd1);

        $display("[TB] multi-beat vectors");
        applyStimulus(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'h01, 8'h01, 8'h01, 8'h01), 1'b1, 1'b0);
        applyStimulus(pk(8'h7F, 8'h00, 8'h00, 8'h00), pk(8'h02, 8'h00, 8'h00, 8'h00), 1'b1, 1'b1);
        popResult("two_beat", 32'd250, 1'b0, t);
        applyStimulus(pk(8'hFF, 8'h00, 8'h00, 8'h00), pk(8'h02, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        applyStimulus(pk(8'hFF, 8'h00, 8'h00, 8'h00), pk(8'h02, 8'h00, 8'h00, 8'h00), 1'b1, 1'b1);
        popResult("mixed_mode", 32'd508, 1'b0, t);

        $display("[TB] output stall");
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(pk(8'd1, 8'd1, 8'd1, 8'd1), pk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
                applyStimulus(pk(8'd2, 8'd2, 8'd2, 8'd2), pk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
                applyStimulus(pk(8'd3, 8'd3, 8'd3, 8'd3), pk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_out_res", out_res, 32'd4);
                out_ready = 1'b1;
            end
        join
        popResult("stall0", 32'd4, 1'b0, t);
        popResult("stall1", 32'd8, 1'b0, t);
        popResult("stall2", 32'd12, 1'b0, t);

        $display("[TB] reset mid-vector");
        applyStimulus(pk(8'd5, 8'd5, 8'd5, 8'd5), pk(8'd5, 8'd5, 8'd5, 8'd5), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_no_output", 32'(got_res.size()), 32'd0);
        applyStimulus(pk(8'd1, 8'd1, 8'd1, 8'd1), pk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
        popResult("midrst_fresh", 32'd4, 1'b0, t);

        $display("[TB] 18-bit accumulator overflow");
        applyNarrow(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b0);
        applyNarrow(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b1);
`ifdef VDOT_SAT_EN
        waitNarrow("ovf_unsigned", 32'd262143, 1'b1);
`else
        waitNarrow("ovf_unsigned", 32'd258056, 1'b0);
`endif
        for (int i = 0; i < 4; i++)
            applyNarrow(pk(8'h80, 8'h80, 8'h80, 8'h80), pk(8'h7F, 8'h7F, 8'h7F, 8'h7F), 1'b1, (i == 3));
`ifdef VDOT_SAT_EN
        waitNarrow("ovf_signed", 32'h20000, 1'b1);
`else
        waitNarrow("ovf_signed", 32'd2048, 1'b0);
`endif
        applyNarrow(pk(8'd1, 8'd1, 8'd1, 8'd1), pk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 1'b1);
        waitNarrow("ovf_cleared", 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
